reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every register, IN, OUT1 and OUT2.
REQ-002 Parameter DEPTH, default 8, SHALL set the register count and SHALL be a power of two, minimum 2.
REQ-003 Local parameter AW SHALL equal clog2(DEPTH) and SHALL set the width of all address ports.
REQ-004 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RESETN  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 IN  input  WIDTH  SHALL be the write data.
REQ-007 WRADDRESS  input  AW  SHALL be the write register index.
REQ-008 WRITE  input  1  SHALL be the write enable, sampled at the CLK rising edge.
REQ-009 RD1ADDRESS  input  AW  SHALL be the read port 1 index.
REQ-010 RD2ADDRESS  input  AW  SHALL be the read port 2 index.
REQ-011 CLEAR  input  1  SHALL request a sequential clear of all registers.
REQ-012 OUT1  output  WIDTH  SHALL be the read port 1 data.
REQ-013 OUT2  output  WIDTH  SHALL be the read port 2 data.
REQ-014 BUSY  output  1  SHALL be high while a clear sequence is in progress.

Function
REQ-015 OUT1 and OUT2 SHALL be combinational reads of the register addressed by RD1ADDRESS and RD2ADDRESS respectively, with zero-cycle latency.
REQ-016 A write SHALL be accepted when WRITE=1, BUSY=0 and CLEAR=0 at the rising edge; the register at WRADDRESS then takes IN at that edge.
REQ-017 The controller SHALL have exactly two states: IDLE (BUSY=0) and CLR (BUSY=1).
REQ-018 CLEAR=1 in IDLE SHALL move the controller to CLR at the next edge, with clear pointer PTR=0.
REQ-019 When CLEAR and WRITE are both high in IDLE, CLEAR SHALL win and the write SHALL be dropped.
REQ-020 Each cycle in CLR, the controller SHALL write register PTR to 0 and increment PTR.
REQ-021 When PTR=DEPTH-1 is cleared, the controller SHALL return to IDLE, so BUSY is high for exactly DEPTH cycles.
REQ-022 WRITE asserted while BUSY=1 SHALL be dropped with no effect on any register.
REQ-023 CLEAR asserted while BUSY=1 SHALL be ignored; the sequence SHALL NOT restart.
REQ-024 Reads during CLR SHALL return current contents: 0 for registers already cleared, old data for the rest.
REQ-025 PTR SHALL be AW bits wide and SHALL wrap to 0 on exit from CLR.
REQ-026 Two read ports addressing the same register SHALL both return identical data.

Reset
REQ-027 RESETN=0 SHALL immediately, without waiting for CLK, set every register to 0, the state to IDLE, BUSY to 0 and PTR to 0.
REQ-028 RESETN=0 during CLR SHALL abort the sequence; all registers SHALL be 0 on release.
REQ-029 OUT1 and OUT2 SHALL read 0 for every address while RESETN=0 and after release until written.
REQ-030 The first accepted write SHALL occur at the first rising edge after RESETN deasserts with WRITE=1.

Configuration
REQ-031 With macro REG_FILE_BYPASS_EN defined, when a write is acceptable in the current cycle (WRITE=1, BUSY=0, CLEAR=0) and RDxADDRESS equals WRADDRESS, OUTx SHALL present IN combinationally.
REQ-032 With REG_FILE_BYPASS_EN undefined, OUTx SHALL present the stored value and show the new data only after the write edge.
REQ-033 Bypass SHALL never apply to dropped writes or during CLR.

Verification
REQ-034 Reset, then write 0xDEADBEEF to reg 3; read RD1=3, RD2=3 -> both read 0xDEADBEEF after the edge; all other registers read 0.
REQ-035 Fill regs 0-7 with 0x11*(i+1), then pulse CLEAR for 1 cycle -> BUSY high for exactly 8 cycles; after 4 cycles regs 0-3 read 0 and reg 4 reads 0x55.
REQ-036 During CLR, WRITE=1 reg 7 with 0xCAFE0000, and CLEAR re-pulsed -> write dropped, no restart; reg 7 reads 0 at end.
REQ-037 In IDLE, assert CLEAR and WRITE (reg 2, 0x1234) in the same cycle -> reg 2 reads 0 after the sequence, BUSY high for 8 cycles.
REQ-038 With reg 5=0xA5A5A5A5, WRITE reg 5 with 0x5A5A5A5A and RD1=5 -> with the macro, OUT1=0x5A5A5A5A before the edge; without it, 0xA5A5A5A5 before and 0x5A5A5A5A after.
REQ-039 Pull RESETN low mid-CLR, between edges -> all outputs 0 immediately, BUSY=0; with WIDTH=16 and DEPTH=16, repeat REQ-035 -> BUSY high 16 cycles.

Source files
------------

// File: rtl/reg_file_param_if.sv
// Register file bus: write port, two read ports, clear request and busy flag.
// The master drives addresses/data/controls; the slave returns read data and BUSY.
interface reg_file_param_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 3
);
   logic [WIDTH-1:0] IN;
   logic [AW-1:0]    WRADDRESS;
   logic             WRITE;
   logic [AW-1:0]    RD1ADDRESS;
   logic [AW-1:0]    RD2ADDRESS;
   logic             CLEAR;
   logic [WIDTH-1:0] OUT1;
   logic [WIDTH-1:0] OUT2;
   logic             BUSY;

   modport master (
      output IN,
      output WRADDRESS,
      output WRITE,
      output RD1ADDRESS,
      output RD2ADDRESS,
      output CLEAR,
      input  OUT1,
      input  OUT2,
      input  BUSY
   );

   modport slave (
      input  IN,
      input  WRADDRESS,
      input  WRITE,
      input  RD1ADDRESS,
      input  RD2ADDRESS,
      input  CLEAR,
      output OUT1,
      output OUT2,
      output BUSY
   );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with two async read ports and a sequential clear.
// Define REG_FILE_BYPASS_EN to forward an acceptable write to matching read ports.
module reg_file_param #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input logic             CLK,
   input logic             RESETN,
   reg_file_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      CLR  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             wr_ok;

   // CLEAR has priority over WRITE; nothing is written while clearing.
   assign wr_ok = (state_q == IDLE) && bus.WRITE && !bus.CLEAR;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      regs_d  = regs_q;
      unique case (state_q)
         IDLE: begin
            if (bus.CLEAR) begin
               state_d = CLR;
               ptr_d   = '0;
            end else if (wr_ok) begin
               regs_d[bus.WRADDRESS] = bus.IN;
            end
         end
         CLR: begin
            regs_d[ptr_q] = '0;
            ptr_d         = ptr_q + AW'(1);
            if (ptr_q == LAST) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == CLR);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign bus.BUSY = busy_q;

`ifdef REG_FILE_BYPASS_EN
   logic byp1;
   logic byp2;

   // Gate with RESETN so the ports read 0 throughout reset.
   assign byp1 = wr_ok && RESETN &&
                 (bus.RD1ADDRESS == bus.WRADDRESS);
   assign byp2 = wr_ok && RESETN &&
                 (bus.RD2ADDRESS == bus.WRADDRESS);

   assign bus.OUT1 = byp1 ? bus.IN
                          : regs_q[bus.RD1ADDRESS];
   assign bus.OUT2 = byp2 ? bus.IN
                          : regs_q[bus.RD2ADDRESS];
`else
   assign bus.OUT1 = regs_q[bus.RD1ADDRESS];
   assign bus.OUT2 = regs_q[bus.RD2ADDRESS];
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: an 8x32 instance and a 16x16 instance.
// Expected values are hand-derived; honours REG_FILE_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_reg_file_param;
   logic clk;
   logic rst_a_n;
   logic rst_b_n;
   int   n_chk;
   int   n_err;
   int   cnt;

   reg_file_param_if #(.WIDTH(32), .AW(3)) bus_a ();
   reg_file_param_if #(.WIDTH(16), .AW(4)) bus_b ();

   reg_file_param #(.WIDTH(32), .DEPTH(8)) u_a (
      .CLK    (clk),
      .RESETN (rst_a_n),
      .bus    (bus_a)
   );

   reg_file_param #(.WIDTH(16), .DEPTH(16)) u_b (
      .CLK    (clk),
      .RESETN (rst_b_n),
      .bus    (bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic rd_chk_a(input string tag, input int a,
                           input logic [31:0] exp);
      bus_a.RD1ADDRESS = a[2:0];
      bus_a.RD2ADDRESS = a[2:0];
      #1;
      check({tag, "_o1"}, bus_a.OUT1, exp);
      check({tag, "_o2"}, bus_a.OUT2, exp);
   endtask

   task automatic rd_chk_b(input string tag, input int a,
                           input logic [31:0] exp);
      bus_b.RD1ADDRESS = a[3:0];
      bus_b.RD2ADDRESS = a[3:0];
      #1;
      check({tag, "_o1"}, {16'h0, bus_b.OUT1}, exp);
      check({tag, "_o2"}, {16'h0, bus_b.OUT2}, exp);
   endtask

   task automatic wr_a(input int a, input logic [31:0] d);
      @(negedge clk);
      bus_a.WRITE     = 1'b1;
      bus_a.WRADDRESS = a[2:0];
      bus_a.IN        = d;
      @(negedge clk);
      bus_a.WRITE = 1'b0;
   endtask

   task automatic wr_b(input int a, input logic [15:0] d);
      @(negedge clk);
      bus_b.WRITE     = 1'b1;
      bus_b.WRADDRESS = a[3:0];
      bus_b.IN        = d;
      @(negedge clk);
      bus_b.WRITE = 1'b0;
   endtask

   task automatic fill_a();
      for (int i = 0; i < 8; i++) begin
         wr_a(i, 32'(32'h11 * (i + 1)));
      end
   endtask

   // Caller raised CLEAR at the previous negedge; counts BUSY-high negedges.
   task automatic clr_run_a(input int mode, output int c);
      c = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus_a.CLEAR = 1'b0;
            bus_a.WRITE = 1'b0;
         end
         if (mode == 1 && i == 2) begin
            bus_a.WRITE     = 1'b1;
            bus_a.WRADDRESS = 3'd7;
            bus_a.IN        = 32'hCAFE0000;
            bus_a.CLEAR     = 1'b1;
         end
         if (mode == 1 && i == 3) begin
            bus_a.WRITE = 1'b0;
            bus_a.CLEAR = 1'b0;
         end
         #1;
         if (!bus_a.BUSY) break;
         c++;
         if (mode == 0 && i == 5) begin
            for (int j = 0; j < 4; j++) rd_chk_a("mid_clr", j, 32'h0);
            rd_chk_a("mid_old4", 4, 32'h55);
         end
         if (mode == 1 && i == 2) rd_chk_a("busy_wr_drop", 7, 32'h77);
         if (mode == 2 && i == 1) rd_chk_a("clr_wr_drop", 2, 32'h99);
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      bus_a.IN = '0; bus_a.WRADDRESS = '0; bus_a.WRITE = 1'b0;
      bus_a.RD1ADDRESS = '0; bus_a.RD2ADDRESS = '0; bus_a.CLEAR = 1'b0;
      bus_b.IN = '0; bus_b.WRADDRESS = '0; bus_b.WRITE = 1'b0;
      bus_b.RD1ADDRESS = '0; bus_b.RD2ADDRESS = '0; bus_b.CLEAR = 1'b0;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      #2;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      #1;
      check("rst_busy_a", {31'h0, bus_a.BUSY}, 32'h0);
      check("rst_busy_b", {31'h0, bus_b.BUSY}, 32'h0);
      rd_chk_a("rst_rd0", 0, 32'h0);
      rd_chk_a("rst_rd7", 7, 32'h0);
      @(negedge clk);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Basic write and dual read of the same register
      wr_a(3, 32'hDEADBEEF);
      rd_chk_a("wr3", 3, 32'hDEADBEEF);
      for (int i = 0; i < 8; i++) begin
         if (i != 3) rd_chk_a("other0", i, 32'h0);
      end

      // Fill and clear, BUSY exactly DEPTH cycles
      fill_a();
      rd_chk_a("fill7", 7, 32'h88);
      @(negedge clk);
      bus_a.CLEAR = 1'b1;
      clr_run_a(0, cnt);
      check("busy_len8", 32'(cnt), 32'd8);
      rd_chk_a("after_clr4", 4, 32'h0);
      rd_chk_a("after_clr7", 7, 32'h0);

      // Write and CLEAR re-pulse during CLR are ignored
      wr_a(7, 32'h77);
      @(negedge clk);
      bus_a.CLEAR = 1'b1;
      clr_run_a(1, cnt);
      check("busy_norestart", 32'(cnt), 32'd8);
      rd_chk_a("r7_end", 7, 32'h0);

      // CLEAR beats a simultaneous WRITE
      wr_a(2, 32'h99);
      @(negedge clk);
      bus_a.CLEAR      = 1'b1;
      bus_a.WRITE      = 1'b1;
      bus_a.WRADDRESS  = 3'd2;
      bus_a.IN         = 32'h1234;
      bus_a.RD1ADDRESS = 3'd2;
      #1;
      check("clr_wr_nobyp", bus_a.OUT1, 32'h99);
      clr_run_a(2, cnt);
      check("busy_clrwr", 32'(cnt), 32'd8);
      rd_chk_a("r2_end", 2, 32'h0);

      // Write-through behaviour before and after the edge
      wr_a(5, 32'hA5A5A5A5);
      @(negedge clk);
      bus_a.WRITE      = 1'b1;
      bus_a.WRADDRESS  = 3'd5;
      bus_a.IN         = 32'h5A5A5A5A;
      bus_a.RD1ADDRESS = 3'd5;
      #1;
`ifdef REG_FILE_BYPASS_EN
      check("byp_pre", bus_a.OUT1, 32'h5A5A5A5A);
`else
      check("nobyp_pre", bus_a.OUT1, 32'hA5A5A5A5);
`endif
      @(negedge clk);
      bus_a.WRITE = 1'b0;
      rd_chk_a("byp_post", 5, 32'h5A5A5A5A);

      // Asynchronous reset in the middle of a clear
      fill_a();
      @(negedge clk);
      bus_a.CLEAR = 1'b1;
      @(negedge clk);
      bus_a.CLEAR = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #3;
      rst_a_n = 1'b0;
      #1;
      check("arst_busy", {31'h0, bus_a.BUSY}, 32'h0);
      for (int i = 0; i < 8; i++) rd_chk_a("arst_rd", i, 32'h0);
      @(negedge clk);
      #2;
      rst_a_n = 1'b1;
      @(negedge clk);
      #1;
      check("rel_busy", {31'h0, bus_a.BUSY}, 32'h0);
      for (int i = 0; i < 8; i++) rd_chk_a("rel_rd", i, 32'h0);
      wr_a(0, 32'hF00D);
      rd_chk_a("first_wr", 0, 32'hF00D);

      // 16x16 instance: same fill/clear scenario, 16 BUSY cycles
      for (int i = 0; i < 16; i++) begin
         wr_b(i, 16'(16'h11 * (i + 1)));
      end
      rd_chk_b("b_fill15", 15, 32'h110);
      @(negedge clk);
      bus_b.CLEAR = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 1) bus_b.CLEAR = 1'b0;
         #1;
         if (!bus_b.BUSY) break;
         cnt++;
         if (i == 5) begin
            for (int j = 0; j < 4; j++) rd_chk_b("b_mid_clr", j, 32'h0);
            rd_chk_b("b_mid_old4", 4, 32'h55);
         end
      end
      check("b_busy_len16", 32'(cnt), 32'd16);
      rd_chk_b("b_end15", 15, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
